// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_mult_state_t;

    // Width of a counter that must hold every value from 0 up to n inclusive.
    function automatic int cntWidth(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/rca_nbit.sv
// N-bit ripple-carry adder: sum/cout = a + b + cin.
module rca_nbit #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N:0] carry;

    // Ripple the carry from bit 0 upward, one full adder per bit.
    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = cin;
        for (int i = 0; i < N; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i+1]   = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        cout = carry[N];
    end

endmodule

// File: rtl/seq_mult_nbit.sv
// Sequential shift-add unsigned multiplier, one partial-product step per clock.
// Operands arrive on a ready/valid handshake, the 2N-bit product leaves on another.
// Optional build macro SEQ_MULT_EARLY_DONE_EN: finish as soon as the remaining
// multiplier bits are all zero instead of always running N steps.
module seq_mult_nbit
    import seq_mult_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] product
);

    localparam int CW = cntWidth(N);

    seq_mult_state_t state_q, state_d;

    // prod_q layout: [2N] carry slot, [2N-1:N] accumulator, [N-1:0] remaining multiplier.
    logic [N-1:0]  mcand_q, mcand_d;
    logic [2*N:0]  prod_q,  prod_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    logic [N-1:0]  addB;
    logic [N-1:0]  sum;
    logic          cout;
    logic [2*N:0]  stepP;
    logic [CW-1:0] cntDec;
    logic          runDone;
`ifdef SEQ_MULT_EARLY_DONE_EN
    logic          remZero;
`endif

    // The carry slot is always zero once a step is stored; the top bit is never consumed.
    logic unusedCarrySlot;
    assign unusedCarrySlot = prod_q[2*N];

    rca_nbit #(.N(N)) uAdder (
        .a    (prod_q[2*N-1:N]),
        .b    (addB),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    // One shift-add step: add the multiplicand when the current multiplier bit is set, then shift right.
    always_comb begin
        addB    = prod_q[0] ? mcand_q : '0;
        stepP   = {1'b0, cout, sum, prod_q[N-1:1]};
        cntDec  = cnt_q - CW'(1);
`ifdef SEQ_MULT_EARLY_DONE_EN
        remZero = 1'b1;
        for (int i = 0; i < N; i++) begin
            if ((CW'(i) < cntDec) && stepP[i]) begin
                remZero = 1'b0;
            end
        end
        runDone = remZero;
`else
        runDone = (cnt_q == CW'(1));
`endif
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accept in IDLE, step in RUN, wait for the consumer in DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (runDone)   state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: load operands on accept, advance one step per RUN cycle, hold otherwise.
    always_comb begin
        mcand_d = mcand_q;
        prod_d  = prod_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d = a;
                    prod_d  = {1'b0, {N{1'b0}}, b};
                    cnt_d   = CW'(N);
                end
            end
            RUN: begin
                cnt_d = cntDec;
`ifdef SEQ_MULT_EARLY_DONE_EN
                prod_d = runDone ? (stepP >> cntDec) : stepP;
`else
                prod_d = stepP;
`endif
            end
            default: begin
            end
        endcase
    end

    // Datapath registers, cleared by reset so no stale operand survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
        end else begin
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
        end
    end

    // Handshake outputs; the product is only exposed in DONE so partial sums never leak.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        product   = '0;
        if (state_q == DONE) begin
            product = prod_q[2*N-1:0];
        end
    end

endmodule

// File: tb/tb_seq_mult_nbit.sv
// Directed testbench for seq_mult_nbit with an N=4 and an N=8 instance.
module tb_seq_mult_nbit;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    logic       inValid4, inReady4, outValid4, outReady4;
    logic [3:0] a4, b4;
    logic [7:0] product4;

    logic        inValid8, inReady8, outValid8, outReady8;
    logic [7:0]  a8, b8;
    logic [15:0] product8;

    seq_mult_nbit #(.N(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (inValid4),
        .in_ready  (inReady4),
        .a         (a4),
        .b         (b4),
        .out_valid (outValid4),
        .out_ready (outReady4),
        .product   (product4)
    );

    seq_mult_nbit #(.N(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (inValid8),
        .in_ready  (inReady8),
        .a         (a8),
        .b         (b8),
        .out_valid (outValid8),
        .out_ready (outReady8),
        .product   (product8)
    );

    logic        sel4;
    logic        selInReady, selOutValid;
    logic [15:0] selProduct;

    // Route the outputs of whichever instance the current vector targets.
    always_comb begin
        if (sel4) begin
            selInReady  = inReady4;
            selOutValid = outValid4;
            selProduct  = {8'b0, product4};
        end else begin
            selInReady  = inReady8;
            selOutValid = outValid8;
            selProduct  = product8;
        end
    end

    int checks = 0;
    int errors = 0;
    int cycleCount = 0;
    int lastAccept = 0;

    // Free-running cycle counter for latency and issue-interval measurements.
    always @(posedge clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Expected RUN cycles between the accept edge and out_valid.
    function automatic int expLatency(input int n, input logic [7:0] bv);
        int lat;
`ifdef SEQ_MULT_EARLY_DONE_EN
        lat = 1;
        for (int i = 0; i < n; i++) begin
            if (bv[i]) lat = i + 1;
        end
`else
        lat = n + 0 * int'(bv);
`endif
        return lat;
    endfunction

    task automatic driveOperands(input logic valid, input logic [7:0] av, input logic [7:0] bv);
        if (sel4) begin
            inValid4 = valid;
            a4       = av[3:0];
            b4       = bv[3:0];
        end else begin
            inValid8 = valid;
            a8       = av;
            b8       = bv;
        end
    endtask

    task automatic setOutReady(input logic r);
        if (sel4) outReady4 = r;
        else      outReady8 = r;
    endtask

    task automatic applyStimulus(input logic useN4, input logic [7:0] av, input logic [7:0] bv,
                                 input int holdCycles, input logic junkWhileBusy,
                                 input logic checkInterval, input logic [15:0] expProd);
        int n;
        int lat;
        int waitCnt;
        int cyc;
        sel4 = useN4;
        n    = useN4 ? 4 : 8;
        lat  = expLatency(n, bv);

        waitCnt = 0;
        while (!selInReady && waitCnt < 50) begin
            @(posedge clk); #1;
            waitCnt++;
        end
        checkOutput("in_ready before accept", {31'b0, selInReady}, 1);

        setOutReady(holdCycles == 0);
        driveOperands(1'b1, av, bv);
        @(posedge clk); #1;
        if (checkInterval) checkOutput("issue interval", cycleCount - lastAccept, lat + 2);
        lastAccept = cycleCount;

        if (junkWhileBusy) driveOperands(1'b1, 8'd1, 8'd1);
        else               driveOperands(1'b0, 8'd0, 8'd0);
        checkOutput("in_ready busy", {31'b0, selInReady}, 0);

        cyc = 0;
        while (!selOutValid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        checkOutput("latency", cyc, lat);
        checkOutput("out_valid", {31'b0, selOutValid}, 1);
        checkOutput("product", {16'b0, selProduct}, {16'b0, expProd});

        for (int i = 0; i < holdCycles; i++) begin
            @(posedge clk); #1;
            checkOutput("held out_valid", {31'b0, selOutValid}, 1);
            checkOutput("held product", {16'b0, selProduct}, {16'b0, expProd});
            checkOutput("held in_ready", {31'b0, selInReady}, 0);
        end

        setOutReady(1'b1);
        @(posedge clk); #1;
        driveOperands(1'b0, 8'd0, 8'd0);
        checkOutput("out_valid after handshake", {31'b0, selOutValid}, 0);
        checkOutput("in_ready after handshake", {31'b0, selInReady}, 1);
    endtask

    // Watchdog so a stuck design still ends the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    // Main directed sequence.
    initial begin
        rst_n = 1'b0;
        sel4  = 1'b0;
        inValid4 = 1'b0; a4 = '0; b4 = '0; outReady4 = 1'b0;
        inValid8 = 1'b0; a8 = '0; b8 = '0; outReady8 = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset in_ready4", {31'b0, inReady4}, 1);
        checkOutput("reset out_valid4", {31'b0, outValid4}, 0);
        checkOutput("reset product4", {24'b0, product4}, 0);
        checkOutput("reset in_ready8", {31'b0, inReady8}, 1);
        checkOutput("reset out_valid8", {31'b0, outValid8}, 0);
        checkOutput("reset product8", {16'b0, product8}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        applyStimulus(1'b1, 8'd13, 8'd11, 0, 1'b0, 1'b0, 16'd143);
        applyStimulus(1'b1, 8'd15, 8'd15, 5, 1'b0, 1'b0, 16'd225);
        applyStimulus(1'b0, 8'd0,  8'd200, 0, 1'b1, 1'b0, 16'd0);
        applyStimulus(1'b0, 8'd200, 8'd0,  0, 1'b0, 1'b1, 16'd0);
        applyStimulus(1'b0, 8'd255, 8'd255, 2, 1'b0, 1'b0, 16'd65025);

        sel4 = 1'b0;
        outReady8 = 1'b1;
        driveOperands(1'b1, 8'd100, 8'd7);
        @(posedge clk); #1;
        driveOperands(1'b0, 8'd0, 8'd0);
        repeat (1) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #2;
        checkOutput("mid-run reset out_valid", {31'b0, outValid8}, 0);
        checkOutput("mid-run reset in_ready", {31'b0, inReady8}, 1);
        checkOutput("mid-run reset product", {16'b0, product8}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            checkOutput("post-reset out_valid", {31'b0, outValid8}, 0);
        end
        checkOutput("post-reset in_ready", {31'b0, inReady8}, 1);
        applyStimulus(1'b0, 8'd100, 8'd7, 0, 1'b0, 1'b0, 16'd700);

        applyStimulus(1'b0, 8'd9,  8'd3,  0, 1'b0, 1'b0, 16'd27);
        applyStimulus(1'b0, 8'd37, 8'd0,  0, 1'b0, 1'b0, 16'd0);
        applyStimulus(1'b0, 8'd13, 8'd11, 0, 1'b0, 1'b0, 16'd143);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_mult_nbit.md
Name: seq_mult_nbit

Overview:
- Sequential shift-add unsigned multiplier, one iteration per clock.
- Sits directly upstream of and around `rca_nbit`. It registers operands, feeds the adder one partial-product step per cycle, and captures sum/cout back into its product register.
- Returns an unsigned 2N-bit product.
- Ready/valid handshakes on both the operand and result sides.

Parameters:
- N, 8, operand width in bits; minimum 2.
- CW, $clog2(N+1), iteration counter width (localparam, not overridable).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands a/b valid
- in_ready  out  1  block can accept operands
- a  in  N  multiplicand, unsigned
- b  in  N  multiplier, unsigned
- out_valid  out  1  product valid
- out_ready  in  1  consumer accepts product
- product  out  2N  a*b, unsigned

Behaviour:
- Reset (async assert, synchronous release): state=IDLE, in_ready=1, out_valid=0, product=0, internal registers=0.
- Registers:
  - mcand[N-1:0].
  - P[2N:0]: P[2N] is the carry slot, P[2N-1:N] the accumulator, P[N-1:0] the remaining multiplier.
  - cnt[CW-1:0].
- IDLE:
  - in_ready=1.
  - On in_valid: mcand<=a, P<={1'b0, N'b0, b}, cnt<=N, go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle the `rca_nbit` instance computes acc+mcand, with cin=0, when P[0]=1; otherwise it computes acc+0.
  - P <= {1'b0, cout, sum, P[N-1:1]} (logical right shift incorporating the carry).
  - cnt decrements.
  - When cnt==1 at the clock edge, go to DONE.
- DONE:
  - out_valid=1, product=P[2N-1:0].
  - Product is held stable while out_ready=0.
  - On out_ready=1: out_valid drops next cycle, go to IDLE.
- Latency: the accept edge is followed by exactly N RUN cycles; out_valid rises on the edge ending the Nth RUN cycle. Minimum issue interval is N+2 cycles.
- No operand acceptance while RUN or DONE; in_valid is ignored there.
- Width rules: sum is N bits and cout is the (N+1)th bit. The product can never exceed 2N bits, so there is no overflow flag.
- Boundaries:
  - a=0 or b=0 yields product 0 after the full latency.
  - a=b=2^N-1 yields (2^N-1)^2.
  - in_valid and out_ready both high in DONE: the result is consumed; the new operand is not accepted until IDLE.
- Reset mid-RUN or mid-DONE: the operation is discarded, outputs return to reset values, and no partial product is ever presented.

Optional Feature:
- Macro: SEQ_MULT_EARLY_DONE_EN.
- Defined: in RUN, if the remaining multiplier bits P[cnt-1:0] are all zero after an update, go straight to DONE with P[2N-1:0] logically right-shifted by the remaining count. Latency becomes (index of highest set bit of b)+1 cycles, with a minimum of 1 (b=0 completes after 1 cycle). Result values are identical to the feature-off case.
- Undefined: fixed N-cycle latency, no zero-detect logic.

Decomposition:
- Package seq_mult_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} seq_mult_state_t.
  - Function clog2-based counter width helper.
- Sub-module: one `rca_nbit` #(.N(N)) instance (existing adder, unchanged) performs the per-step addition. All sequencing stays in seq_mult_nbit.

Test Plan:
- N=4, a=13, b=11, out_ready=1 -> out_valid exactly 4 cycles after accept edge, product=143 (0x8F).
- N=4, a=15, b=15, out_ready held 0 for 5 cycles then 1 -> product=225 stable throughout, in_ready=0 until one cycle after the handshake.
- N=8, a=0, b=200 and a=200, b=0 back-to-back -> both products 0; issue interval ≥10 cycles; second in_valid ignored while busy.
- N=8, a=255, b=255 -> product=65025 (0xFE01); exercises a carry into P[2N-1] on the final step.
- N=8, a=100, b=7, rst_n pulsed low mid-RUN -> out_valid stays 0, in_ready=1 after release; a fresh 100*7 then yields 700.
- With SEQ_MULT_EARLY_DONE_EN, N=8, a=9, b=3 -> product=27 after 2 RUN cycles; b=0 -> product 0 after 1 cycle.
